// File: rtl/sdram_arbiter.sv
// ----------------------------------------------------------------------------
// sdram_arbiter
//   Two-port round-robin arbiter and sequencer in front of the 8-bit SDRAM
//   controller. Port 0 is the GPMC host register path, port 1 an on-fabric
//   engine. Each port issues a held req/we/addr/wdata transaction and gets a
//   one-cycle ack when it is accepted; reads return data with a one-cycle
//   rvalid pulse on the owning port only. A stalled controller is recovered
//   by a per-state timeout that aborts back to IDLE with timeout_err.
//
// Ports
//   clk, rst_n              clock, synchronous active-low reset
//   pN_req/we/addr/wdata    port N request (held until pN_ack)
//   pN_ack                  one-cycle accept pulse
//   pN_rdata, pN_rvalid     last read data (held) and its valid pulse
//   sd_wr_addr/data/enable  controller write side
//   sd_rd_addr/enable       controller read side (address mirrors write addr)
//   sd_rd_data/ready, busy  controller responses
//   grant                   owner of the current or last transaction
//   active                  high whenever the sequencer is not IDLE
//   timeout_err             one-cycle pulse on abort
// ----------------------------------------------------------------------------

// Per-port return path: ack pulse, rvalid pulse and held read data.
module sdram_arbiter_port #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ack_set,
    input  logic                  rd_cap,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  ack,
    output logic                  rvalid,
    output logic [DATA_WIDTH-1:0] rdata
);
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ack    <= 1'b0;
            rvalid <= 1'b0;
            rdata  <= '0;
        end else begin
            ack    <= ack_set;
            rvalid <= rd_cap;
            // rdata only moves on a capture aimed at this port
            if (rd_cap)
                rdata <= rd_data;
        end
    end
endmodule

module sdram_arbiter #(
    parameter int ADDR_WIDTH = 25,
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  p0_req,
    input  logic                  p0_we,
    input  logic [ADDR_WIDTH-1:0] p0_addr,
    input  logic [DATA_WIDTH-1:0] p0_wdata,
    output logic                  p0_ack,
    output logic [DATA_WIDTH-1:0] p0_rdata,
    output logic                  p0_rvalid,
    input  logic                  p1_req,
    input  logic                  p1_we,
    input  logic [ADDR_WIDTH-1:0] p1_addr,
    input  logic [DATA_WIDTH-1:0] p1_wdata,
    output logic                  p1_ack,
    output logic [DATA_WIDTH-1:0] p1_rdata,
    output logic                  p1_rvalid,
    output logic [ADDR_WIDTH-1:0] sd_wr_addr,
    output logic [DATA_WIDTH-1:0] sd_wr_data,
    output logic                  sd_wr_enable,
    output logic [ADDR_WIDTH-1:0] sd_rd_addr,
    output logic                  sd_rd_enable,
    input  logic [DATA_WIDTH-1:0] sd_rd_data,
    input  logic                  sd_rd_ready,
    input  logic                  sd_busy,
    output logic                  grant,
    output logic                  active,
    output logic                  timeout_err
);
    localparam int NUM_PORTS = 2;
    localparam int CNT_W     = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT_RD = 2'd2,
        ST_DRAIN   = 2'd3
    } state_t;

    // Request side gathered into per-port arrays so the winner is a mux index
    logic [NUM_PORTS-1:0]                 req;
    logic [NUM_PORTS-1:0]                 req_we;
    logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] req_addr;
    logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] req_wdata;
    logic [NUM_PORTS-1:0]                 port_ack;
    logic [NUM_PORTS-1:0]                 port_rvalid;
    logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] port_rdata;

    assign req       = {p1_req, p0_req};
    assign req_we    = {p1_we, p0_we};
    assign req_addr  = {p1_addr, p0_addr};
    assign req_wdata = {p1_wdata, p0_wdata};

    // Registered state
    state_t                state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  last_grant_q;
    logic                  grant_q;
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  wr_en_q;
    logic                  rd_en_q;
    logic                  active_q;
    logic                  err_q;

    // Next-state values
    state_t                state_n;
    logic [CNT_W-1:0]      cnt_n;
    logic [CNT_W-1:0]      cnt_inc;
    logic                  tmo_hit;
    logic                  win;
    logic                  last_grant_n;
    logic                  grant_n;
    logic                  we_n;
    logic [ADDR_WIDTH-1:0] addr_n;
    logic [DATA_WIDTH-1:0] wdata_n;
    logic                  wr_en_n;
    logic                  rd_en_n;
    logic                  err_n;
    logic [NUM_PORTS-1:0]  ack_set;
    logic [NUM_PORTS-1:0]  rd_cap;

    // Abort on the edge where the count would reach TIMEOUT-1, so a state is
    // never occupied for more than TIMEOUT-1 cycles.
    assign cnt_inc = cnt_q + CNT_W'(1);
    assign tmo_hit = (cnt_inc == TMO_LAST);

    always_comb begin
        state_n      = state_q;
        last_grant_n = last_grant_q;
        grant_n      = grant_q;
        we_n         = we_q;
        addr_n       = addr_q;
        wdata_n      = wdata_q;
        wr_en_n      = wr_en_q;
        rd_en_n      = rd_en_q;
        err_n        = 1'b0;
        ack_set      = '0;
        rd_cap       = '0;
        win          = 1'b0;
        cnt_n        = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (!sd_busy && (req != '0)) begin
                    // Contention goes to the port that did not win last time
                    win          = (&req) ? ~last_grant_q : req[1];
                    grant_n      = win;
                    last_grant_n = win;
                    ack_set[win] = 1'b1;
                    we_n         = req_we[win];
                    addr_n       = req_addr[win];
                    wdata_n      = req_wdata[win];
                    wr_en_n      = req_we[win];
                    rd_en_n      = ~req_we[win];
                    state_n      = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // Busy acknowledges the command; it outranks a same-cycle timeout
                if (sd_busy) begin
                    wr_en_n = 1'b0;
                    rd_en_n = 1'b0;
                    state_n = we_q ? ST_DRAIN : ST_WAIT_RD;
                end else if (tmo_hit) begin
                    wr_en_n = 1'b0;
                    rd_en_n = 1'b0;
                    err_n   = 1'b1;
                    state_n = ST_IDLE;
                end
            end
            ST_WAIT_RD: begin
                if (sd_rd_ready) begin
                    rd_cap[grant_q] = 1'b1;
                    state_n         = sd_busy ? ST_DRAIN : ST_IDLE;
                end else if (tmo_hit) begin
                    err_n   = 1'b1;
                    state_n = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (!sd_busy) begin
                    state_n = ST_IDLE;
                end else if (tmo_hit) begin
                    err_n   = 1'b1;
                    state_n = ST_IDLE;
                end
            end
            default: begin
                wr_en_n = 1'b0;
                rd_en_n = 1'b0;
                state_n = ST_IDLE;
            end
        endcase

        // Counter restarts on every state change and idles at zero
        if (state_n == state_q && state_q != ST_IDLE)
            cnt_n = cnt_inc;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            wr_en_q      <= 1'b0;
            rd_en_q      <= 1'b0;
            active_q     <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_n;
            cnt_q        <= cnt_n;
            last_grant_q <= last_grant_n;
            grant_q      <= grant_n;
            we_q         <= we_n;
            addr_q       <= addr_n;
            wdata_q      <= wdata_n;
            wr_en_q      <= wr_en_n;
            rd_en_q      <= rd_en_n;
            active_q     <= (state_n != ST_IDLE);
            err_q        <= err_n;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
            sdram_arbiter_port #(
                .DATA_WIDTH(DATA_WIDTH)
            ) u_port (
                .clk    (clk),
                .rst_n  (rst_n),
                .ack_set(ack_set[gi]),
                .rd_cap (rd_cap[gi]),
                .rd_data(sd_rd_data),
                .ack    (port_ack[gi]),
                .rvalid (port_rvalid[gi]),
                .rdata  (port_rdata[gi])
            );
        end
    endgenerate

    assign p0_ack       = port_ack[0];
    assign p1_ack       = port_ack[1];
    assign p0_rvalid    = port_rvalid[0];
    assign p1_rvalid    = port_rvalid[1];
    assign p0_rdata     = port_rdata[0];
    assign p1_rdata     = port_rdata[1];
    assign sd_wr_addr   = addr_q;
    assign sd_rd_addr   = addr_q;
    assign sd_wr_data   = wdata_q;
    assign sd_wr_enable = wr_en_q;
    assign sd_rd_enable = rd_en_q;
    assign grant        = grant_q;
    assign active       = active_q;
    assign timeout_err  = err_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter (TIMEOUT=16). Inputs are driven and
// outputs sampled 1ns after each rising edge.
module tb_sdram_arbiter;
    localparam int AW = 25;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          p0_req, p0_we, p1_req, p1_we;
    logic [AW-1:0] p0_addr, p1_addr;
    logic [DW-1:0] p0_wdata, p1_wdata;
    logic          p0_ack, p1_ack, p0_rvalid, p1_rvalid;
    logic [DW-1:0] p0_rdata, p1_rdata;
    logic [AW-1:0] sd_wr_addr, sd_rd_addr;
    logic [DW-1:0] sd_wr_data, sd_rd_data;
    logic          sd_wr_enable, sd_rd_enable, sd_rd_ready, sd_busy;
    logic          grant, active, timeout_err;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    sdram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_ack(p0_ack), .p0_rdata(p0_rdata), .p0_rvalid(p0_rvalid),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_ack(p1_ack), .p1_rdata(p1_rdata), .p1_rvalid(p1_rvalid),
        .sd_wr_addr(sd_wr_addr), .sd_wr_data(sd_wr_data), .sd_wr_enable(sd_wr_enable),
        .sd_rd_addr(sd_rd_addr), .sd_rd_enable(sd_rd_enable),
        .sd_rd_data(sd_rd_data), .sd_rd_ready(sd_rd_ready), .sd_busy(sd_busy),
        .grant(grant), .active(active), .timeout_err(timeout_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [8:0]        ctl;
        logic [2*AW+3*DW-1:0] dat;
        rst_n = 1'b0;
        p0_req = 0; p0_we = 0; p0_addr = '0; p0_wdata = '0;
        p1_req = 0; p1_we = 0; p1_addr = '0; p1_wdata = '0;
        sd_rd_data = '0; sd_rd_ready = 0; sd_busy = 0;
        repeat (3) tick();
        ctl = {p0_ack, p1_ack, p0_rvalid, p1_rvalid, sd_wr_enable, sd_rd_enable, grant, active, timeout_err};
        dat = {sd_wr_addr, sd_rd_addr, sd_wr_data, p0_rdata, p1_rdata};
        tests++; if (ctl !== 9'b0) begin fails++; $display("FAIL reset_ctl got=%b exp=0", ctl); end
        tests++; if (dat !== '0) begin fails++; $display("FAIL reset_data got=%h exp=0", dat); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_write();
        p0_req = 1; p0_we = 1; p0_addr = 25'h0012345; p0_wdata = 8'hA5;
        tick();
        tests++; if ({p0_ack, p1_ack, sd_wr_enable, sd_rd_enable, grant, active} !== 6'b101001) begin
            fails++; $display("FAIL wr_accept got=%b exp=101001", {p0_ack, p1_ack, sd_wr_enable, sd_rd_enable, grant, active}); end
        tests++; if ({sd_wr_addr, sd_rd_addr, sd_wr_data} !== {25'h0012345, 25'h0012345, 8'hA5}) begin
            fails++; $display("FAIL wr_fields got=%h/%h/%h exp=0012345/0012345/a5", sd_wr_addr, sd_rd_addr, sd_wr_data); end
        p0_req = 0;
        tick();
        tests++; if ({p0_ack, sd_wr_enable} !== 2'b01) begin
            fails++; $display("FAIL wr_ack_pulse got=%b exp=01", {p0_ack, sd_wr_enable}); end
        tick();
        tests++; if (sd_wr_enable !== 1'b1) begin fails++; $display("FAIL wr_en_hold got=%b exp=1", sd_wr_enable); end
        sd_busy = 1;
        tick();
        tests++; if ({sd_wr_enable, active} !== 2'b01) begin
            fails++; $display("FAIL wr_en_drop got=%b exp=01", {sd_wr_enable, active}); end
        for (int i = 0; i < 9; i++) begin
            tick();
            tests++; if ({active, sd_wr_enable, p0_rvalid, p1_rvalid} !== 4'b1000) begin
                fails++; $display("FAIL wr_drain cyc=%0d got=%b exp=1000", i, {active, sd_wr_enable, p0_rvalid, p1_rvalid}); end
        end
        sd_busy = 0;
        tick();
        tests++; if ({active, p0_rvalid, p1_rvalid} !== 3'b000) begin
            fails++; $display("FAIL wr_done got=%b exp=000", {active, p0_rvalid, p1_rvalid}); end
        tests++; if ({sd_wr_addr, sd_wr_data} !== {25'h0012345, 8'hA5}) begin
            fails++; $display("FAIL wr_addr_hold got=%h/%h exp=0012345/a5", sd_wr_addr, sd_wr_data); end
    endtask

    task automatic test_single_read();
        p1_req = 1; p1_we = 0; p1_addr = 25'h1000000;
        tick();
        tests++; if ({p1_ack, sd_rd_enable, sd_wr_enable, grant} !== 4'b1101) begin
            fails++; $display("FAIL rd_accept got=%b exp=1101", {p1_ack, sd_rd_enable, sd_wr_enable, grant}); end
        tests++; if (sd_rd_addr !== 25'h1000000) begin fails++; $display("FAIL rd_addr got=%h exp=1000000", sd_rd_addr); end
        p1_req = 0; sd_busy = 1;
        tick();
        tests++; if (sd_rd_enable !== 1'b0) begin fails++; $display("FAIL rd_en_drop got=%b exp=0", sd_rd_enable); end
        tick();
        sd_rd_data = 8'h3C; sd_rd_ready = 1;
        tick();
        sd_rd_ready = 0; sd_rd_data = 8'h00;
        tests++; if ({p1_rvalid, p1_rdata, p0_rvalid, p0_rdata} !== {1'b1, 8'h3C, 1'b0, 8'h00}) begin
            fails++; $display("FAIL rd_return got=%b/%h p0=%b/%h exp=1/3c p0=0/00", p1_rvalid, p1_rdata, p0_rvalid, p0_rdata); end
        tick();
        tests++; if ({p1_rvalid, p1_rdata, active} !== {1'b0, 8'h3C, 1'b1}) begin
            fails++; $display("FAIL rd_rvalid_pulse got=%b/%h/%b exp=0/3c/1", p1_rvalid, p1_rdata, active); end
        sd_busy = 0;
        tick();
        tests++; if ({active, grant} !== 2'b01) begin fails++; $display("FAIL rd_done got=%b exp=01", {active, grant}); end
    endtask

    task automatic test_contention();
        logic [1:0]    exp_ack;
        logic [AW-1:0] exp_addr;
        p0_req = 1; p0_we = 1; p0_addr = 25'h0000AAA; p0_wdata = 8'h11;
        p1_req = 1; p1_we = 1; p1_addr = 25'h1555555; p1_wdata = 8'h22;
        for (int k = 0; k < 4; k++) begin
            exp_ack  = (k % 2 == 0) ? 2'b01 : 2'b10;
            exp_addr = (k % 2 == 0) ? 25'h0000AAA : 25'h1555555;
            tick();
            tests++; if ({p1_ack, p0_ack} !== exp_ack || grant !== exp_ack[1] || sd_wr_addr !== exp_addr) begin
                fails++; $display("FAIL cont_grant k=%0d ack=%b grant=%b addr=%h exp ack=%b grant=%b addr=%h",
                    k, {p1_ack, p0_ack}, grant, sd_wr_addr, exp_ack, exp_ack[1], exp_addr); end
            sd_busy = 1;
            tick();
            tests++; if ({p1_ack, p0_ack, sd_wr_enable} !== 3'b000) begin
                fails++; $display("FAIL cont_ack_pulse k=%0d got=%b exp=000", k, {p1_ack, p0_ack, sd_wr_enable}); end
            sd_busy = 0;
            tick();
            tests++; if ({active, p1_ack, p0_ack} !== 3'b000) begin
                fails++; $display("FAIL cont_idle_gap k=%0d got=%b exp=000", k, {active, p1_ack, p0_ack}); end
        end
        p0_req = 0; p1_req = 0;
        tick();
        tests++; if ({active, p1_ack, p0_ack} !== 3'b000) begin
            fails++; $display("FAIL cont_quiet got=%b exp=000", {active, p1_ack, p0_ack}); end
    endtask

    task automatic test_stall_timeout();
        p0_req = 1; p0_we = 0; p0_addr = 25'h0000777;
        tick();
        tests++; if ({p0_ack, sd_rd_enable} !== 2'b11) begin
            fails++; $display("FAIL stall_accept got=%b exp=11", {p0_ack, sd_rd_enable}); end
        p0_req = 0;
        for (int k = 1; k < 15; k++) begin
            tick();
            tests++; if ({sd_rd_enable, timeout_err} !== 2'b10) begin
                fails++; $display("FAIL stall_wait cyc=%0d got=%b exp=10", k, {sd_rd_enable, timeout_err}); end
        end
        tick();
        tests++; if ({timeout_err, sd_rd_enable, active, p0_rvalid, p1_rvalid} !== 5'b10000) begin
            fails++; $display("FAIL stall_abort got=%b exp=10000", {timeout_err, sd_rd_enable, active, p0_rvalid, p1_rvalid}); end
        tick();
        tests++; if ({timeout_err, p0_rdata, p1_rdata} !== {1'b0, 8'h00, 8'h3C}) begin
            fails++; $display("FAIL stall_after got=%b/%h/%h exp=0/00/3c", timeout_err, p0_rdata, p1_rdata); end
        p1_req = 1; p1_we = 1; p1_addr = 25'h0000042; p1_wdata = 8'h5A;
        tick();
        tests++; if ({p1_ack, sd_wr_enable, sd_wr_data} !== {2'b11, 8'h5A}) begin
            fails++; $display("FAIL stall_recover got=%b/%b/%h exp=1/1/5a", p1_ack, sd_wr_enable, sd_wr_data); end
        p1_req = 0; sd_busy = 1;
        tick();
        sd_busy = 0;
        tick();
    endtask

    task automatic test_reset_mid_read();
        logic [8:0] ctl;
        p0_req = 1; p0_we = 0; p0_addr = 25'h0000100;
        tick();
        tests++; if (p0_ack !== 1'b1) begin fails++; $display("FAIL rst_rd_accept got=%b exp=1", p0_ack); end
        p0_req = 0; sd_busy = 1;
        tick();
        tick();
        rst_n = 0;
        tick();
        ctl = {p0_ack, p1_ack, p0_rvalid, p1_rvalid, sd_wr_enable, sd_rd_enable, grant, active, timeout_err};
        tests++; if (ctl !== 9'b0 || {sd_wr_addr, sd_wr_data, p0_rdata, p1_rdata} !== '0) begin
            fails++; $display("FAIL rst_mid_clear ctl=%b addr=%h p1_rdata=%h exp 0", ctl, sd_wr_addr, p1_rdata); end
        rst_n = 1; sd_busy = 0; sd_rd_ready = 1; sd_rd_data = 8'h77;
        tick();
        sd_rd_ready = 0;
        tests++; if ({p0_rvalid, p1_rvalid, p0_rdata, p1_rdata, timeout_err} !== '0) begin
            fails++; $display("FAIL rst_stray_ready got=%b%b %h %h %b exp=0", p0_rvalid, p1_rvalid, p0_rdata, p1_rdata, timeout_err); end
        p0_req = 1; p0_we = 1; p1_req = 1; p1_we = 1;
        tick();
        tests++; if ({p1_ack, p0_ack, grant} !== 3'b010) begin
            fails++; $display("FAIL rst_first_grant got=%b exp=010", {p1_ack, p0_ack, grant}); end
        p0_req = 0; p1_req = 0; sd_busy = 1;
        tick();
        sd_busy = 0;
        tick();
    endtask

    task automatic test_busy_gating();
        sd_busy = 1;
        p0_req = 1; p0_we = 1; p0_addr = 25'h0000ABC; p0_wdata = 8'h99;
        for (int k = 0; k < 3; k++) begin
            tick();
            tests++; if ({p0_ack, p1_ack, active} !== 3'b000) begin
                fails++; $display("FAIL busy_hold cyc=%0d got=%b exp=000", k, {p0_ack, p1_ack, active}); end
        end
        sd_busy = 0;
        tick();
        tests++; if ({p0_ack, sd_wr_enable, sd_wr_addr} !== {2'b11, 25'h0000ABC}) begin
            fails++; $display("FAIL busy_release got=%b/%b/%h exp=1/1/0000abc", p0_ack, sd_wr_enable, sd_wr_addr); end
        p0_req = 0; sd_busy = 1;
        tick();
        sd_busy = 0;
        tick();
        tests++; if (active !== 1'b0) begin fails++; $display("FAIL busy_done got=%b exp=0", active); end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_single_read();
        test_contention();
        test_stall_timeout();
        test_reset_mid_read();
        test_busy_gating();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
